// File: rtl/adder_pkg.sv
// Shared types and limits for the bit-serial adder family.
package adder_pkg;

    localparam int unsigned ST_W      = 1;
    localparam int unsigned MAX_WIDTH = 64;

    typedef enum logic [ST_W-1:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit full adder: two half-adder stages with their carries ORed.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    logic s1;
    logic c1;
    logic c2;

    assign s1 = x ^ y;
    assign c1 = x & y;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB first, start/busy/done handshake.
module serial_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_adder: WIDTH out of range");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   s_sr_q, s_sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               c_msb_q, c_msb_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fa_s;
    logic               fa_co;
    logic [WIDTH-1:0]   s_shift;

    fa_cell u_fa (
        .x  (a_sr_q[0]),
        .y  (b_sr_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign s_shift = {fa_s, s_sr_q[WIDTH-1:1]};

    // Next-state: load operands in IDLE, consume one bit per edge in RUN.
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        s_sr_d  = s_sr_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        c_msb_d = c_msb_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_sr_d  = s_shift;
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 2)) begin
                    c_msb_d = fa_co;
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    sum_d   = s_shift;
                    cout_d  = fa_co;
                    ovf_d   = c_msb_q ^ fa_co;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            s_sr_q  <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            c_msb_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            s_sr_q  <= s_sr_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            c_msb_q <= c_msb_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: 8-bit and 2-bit instances, directed vectors.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    logic       start8 = 1'b0, sub8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;

    logic       start2 = 1'b0, sub2 = 1'b0, cin2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;

    typedef struct {
        logic [7:0] s;
        logic       co;
        logic       ov;
        int         c;
    } exp_t;

    exp_t q8[$];
    exp_t q2[$];
    exp_t m8, m2;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
        .a(a8), .b(b8), .busy(busy8), .done(done8), .sum(sum8),
        .cout(cout8), .ovf(ovf8)
    );

    serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .cin(cin2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .sum(sum2),
        .cout(cout2), .ovf(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop the oldest expectation whenever a done pulse is seen.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                total++; bad++;
                $display("FAIL done8_unexpected: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                m8 = q8.pop_front();
                chk("sum8", 64'(sum8), 64'(m8.s));
                chk("cout8", 64'(cout8), 64'(m8.co));
                chk("ovf8", 64'(ovf8), 64'(m8.ov));
                chk("done8_cycle", 64'(cyc), 64'(m8.c));
            end
        end
        if (rst_n === 1'b1 && done2 === 1'b1) begin
            if (q2.size() == 0) begin
                total++; bad++;
                $display("FAIL done2_unexpected: got done=1 expected none (cycle %0d)", cyc);
            end else begin
                m2 = q2.pop_front();
                chk("sum2", 64'(sum2), 64'(m2.s[1:0]));
                chk("cout2", 64'(cout2), 64'(m2.co));
                chk("ovf2", 64'(ovf2), 64'(m2.ov));
                chk("done2_cycle", 64'(cyc), 64'(m2.c));
            end
        end
    end

    // Called at a negedge; returns at the negedge after the sampling edge.
    task automatic launch8(input logic s, input logic c, input logic [7:0] aa,
                           input logic [7:0] bb, input logic [7:0] es,
                           input logic eco, input logic eov);
        exp_t e;
        e.s = es; e.co = eco; e.ov = eov; e.c = cyc + 1 + 8;
        sub8 = s; cin8 = c; a8 = aa; b8 = bb; start8 = 1'b1;
        q8.push_back(e);
        @(posedge clk);
        #1;
        start8 = 1'b0; a8 = ~aa; b8 = ~bb; sub8 = ~s; cin8 = ~c;
        @(negedge clk);
    endtask

    task automatic launch2(input logic s, input logic c, input logic [1:0] aa,
                           input logic [1:0] bb, input logic [1:0] es,
                           input logic eco, input logic eov);
        exp_t e;
        e.s = {6'b0, es}; e.co = eco; e.ov = eov; e.c = cyc + 1 + 2;
        sub2 = s; cin2 = c; a2 = aa; b2 = bb; start2 = 1'b1;
        q2.push_back(e);
        @(posedge clk);
        #1;
        start2 = 1'b0; a2 = ~aa; b2 = ~bb;
        @(negedge clk);
    endtask

    // Returns at the negedge where done is visible; nb counts busy cycles seen.
    task automatic wait_done8(output int nb);
        bit seen = 1'b0;
        nb = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (done8) seen = 1'b1;
            else begin
                if (busy8) nb++;
                @(negedge clk);
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_done8: got no done expected done within 40 cycles");
        end
    endtask

    task automatic wait_done2();
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (done2) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL wait_done2: got no done expected done within 20 cycles");
        end
    endtask

    initial begin
        int nb;
        repeat (3) @(negedge clk);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_sum8",  64'(sum8),  64'd0);
        chk("rst_cout8", 64'(cout8), 64'd0);
        chk("rst_ovf8",  64'(ovf8),  64'd0);
        chk("rst_busy2", 64'(busy2), 64'd0);
        chk("rst_sum2",  64'(sum2),  64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic add with latency and busy-length checks.
        launch8(1'b0, 1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
        wait_done8(nb);
        chk("busy8_cycles", 64'(nb), 64'd8);
        @(negedge clk);
        chk("done8_pulse_drop", 64'(done8), 64'd0);

        launch8(1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        wait_done8(nb);
        @(negedge clk);
        launch8(1'b0, 1'b1, 8'hFF, 8'h01, 8'h01, 1'b1, 1'b0);
        wait_done8(nb);
        @(negedge clk);

        launch8(1'b1, 1'b0, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
        wait_done8(nb);
        @(negedge clk);
        launch8(1'b1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
        wait_done8(nb);
        @(negedge clk);

        // Start during RUN cycle 3 must be ignored.
        launch8(1'b0, 1'b0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b0; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        chk("busy8_after_ignored", 64'(busy8), 64'd1);
        wait_done8(nb);

        // Back-to-back: second start issued in the done cycle.
        @(negedge clk);
        launch8(1'b0, 1'b0, 8'h70, 8'h10, 8'h80, 1'b0, 1'b1);
        wait_done8(nb);
        launch8(1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
        chk("sum8_held", 64'(sum8), 64'h80);
        chk("ovf8_held", 64'(ovf8), 64'd1);
        chk("busy8_b2b", 64'(busy8), 64'd1);
        wait_done8(nb);
        @(negedge clk);

        // Asynchronous reset mid-RUN.
        launch8(1'b0, 1'b0, 8'hAA, 8'h11, 8'hBB, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy8", 64'(busy8), 64'd0);
        chk("arst_done8", 64'(done8), 64'd0);
        chk("arst_sum8",  64'(sum8),  64'd0);
        chk("arst_cout8", 64'(cout8), 64'd0);
        chk("arst_ovf8",  64'(ovf8),  64'd0);
        q8.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_idle_busy8", 64'(busy8), 64'd0);
        launch8(1'b0, 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        wait_done8(nb);
        @(negedge clk);

        // Minimum width instance.
        launch2(1'b0, 1'b0, 2'b11, 2'b01, 2'b00, 1'b1, 1'b0);
        wait_done2();
        @(negedge clk);
        launch2(1'b0, 1'b0, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1);
        wait_done2();
        @(negedge clk);
        launch2(1'b1, 1'b0, 2'b01, 2'b10, 2'b11, 1'b0, 1'b1);
        wait_done2();

        repeat (12) @(negedge clk);
        chk("q8_drained", 64'(q8.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor; the sequential successor to the team's combinational semiadder cells.
- Adds or subtracts two WIDTH-bit operands one bit per clock, LSB first. The carry is held in a flip-flop between bits.
- Uses a start/busy/done handshake so that a controller or switch/LED test harness can launch an operation and collect the result.
- Trades latency for area: one full-adder cell serves every width.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, never overridden.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch request; sampled only in IDLE.
- sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
- cin  input  1  carry-in for add; ignored when sub=1 (forced 1). Sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal shift registers, carry and counter all 0.
- Reset release is synchronous to the next clk edge.
- States: IDLE, RUN. The state register is the only FSM; done is a registered flag, not a state.
- IDLE: start=1 at edge E0 causes:
  - a_sr <= a; b_sr <= b XOR {WIDTH{sub}}; carry <= sub ? 1 : cin; cnt <= 0;
  - busy <= 1; state <= RUN.
  - sum/cout/ovf keep their old values until completion.
- RUN, at each edge:
  - The full-adder cell takes a_sr[0], b_sr[0] and carry.
  - Its sum bit shifts into the sum shift register from the MSB side. a_sr and b_sr shift right by 1.
  - carry <= cell carry-out; cnt <= cnt+1.
  - When cnt==WIDTH-2, the cell carry-out is also captured as c_msb_in (carry into MSB).
- Completion: the edge where cnt==WIDTH-1 processes the last bit. That edge is E0+WIDTH. At it:
  - sum <= final shifted value; cout <= cell carry-out; ovf <= c_msb_in XOR cell carry-out;
  - done <= 1; busy <= 0; state <= IDLE.
- done deasserts on the following edge unless a new operation completes on it (impossible for WIDTH>=2).
- Latency: result is valid WIDTH edges after the start-sampling edge. Throughput is one operation per WIDTH+1 cycles at best.
- start while busy=1 is ignored. There is no queueing and no error flag.
- start in the done cycle is accepted, since state is IDLE. sum/cout/ovf remain valid through that cycle and change only at the new completion edge.
- Operand inputs may change freely after the sampling edge; they do not affect the operation in flight.
- Reset mid-RUN aborts immediately: all outputs return to reset values and no done pulse is produced.
- Width rules:
  - sum is modulo 2^WIDTH.
  - Add: cout = bit WIDTH of a+b+cin.
  - Sub: sum = a + ~b + 1; cout = (a >= b) unsigned; ovf flags signed overflow.

Decomposition:
- Shared package (adder_pkg): FSM state enum {IDLE, RUN}; localparams ST_W=1 and MAX_WIDTH=64.
- One sub-module: fa_cell, a 1-bit full adder built from two semiadder-style half-adder stages plus an OR on the carries. It is purely combinational, with ports x, y, ci, s, co.
- Counter, shift registers and FSM live in serial_adder.

Test Plan:
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> done exactly 8 edges after start; sum=0x96, cout=0, ovf=1; busy high for 8 cycles.
- WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Repeat with cin=1 -> sum=0x01, cout=1.
- WIDTH=8, sub, a=0x10, b=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- WIDTH=8:
  - Pulse start again at cycle 3 of RUN with different operands -> ignored; first result is unchanged.
  - Back-to-back start in the done cycle -> accepted; second done arrives 8 edges later.
- WIDTH=8, drop rst_n at RUN cycle 4 -> busy, done, sum, cout, ovf are all 0 immediately (asynchronous). After release, a fresh operation 0x01+0x01 -> sum=0x02.
- WIDTH=2 instance, add, a=2'b11, b=2'b01 -> sum=2'b00, cout=1, ovf=0, done after 2 edges. Cross-check against two semiadder-equivalent bit results.
